// File: rtl/ctrl_ringaddr.sv
// Per-channel circular-buffer address generator for a register-file ring.
// Falling-edge state, async active-low reset, init sweep per channel.
module ctrl_ringaddr #(
  parameter int WIDTH = 3,
  parameter int DEPTH = 8,
  parameter int NCH   = 2,
  localparam int CHW  = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CHW-1:0]   ch,
  input  logic             en_init,
  input  logic             en_load,
  input  logic             new_smp,
  input  logic             out_smp,
  input  logic [WIDTH-1:0] result_reg,
  input  logic [WIDTH-1:0] error_reg,
  output logic [WIDTH-1:0] ares,
  output logic [WIDTH-1:0] aerr,
  output logic [WIDTH-1:0] head,
  output logic             addr_vld,
  output logic             busy,
  output logic             oob
);

  localparam logic [WIDTH:0]   DEP  = (WIDTH+1)'(DEPTH);
  localparam logic [WIDTH-1:0] DLO  = WIDTH'(DEPTH);
  localparam logic [WIDTH-1:0] DMAX = WIDTH'(DEPTH - 1);

  typedef enum logic {IDLE, INIT} state_t;

  state_t                      state_q, state_d;
  logic [WIDTH-1:0]            cnt_q, cnt_d;
  logic [CHW-1:0]              ich_q, ich_d;
  logic [NCH-1:0][WIDTH-1:0]   head_q, head_d;
  logic [WIDTH-1:0]            ares_q, ares_d;
  logic [WIDTH-1:0]            aerr_q, aerr_d;
  logic                        vld_q, vld_d;
  logic                        oob_q, oob_d;

  logic                        ch_ok;
  logic [WIDTH-1:0]            hsel;
  logic                        rr_big;
  logic [WIDTH-1:0]            rr;
  logic [WIDTH:0]              sum;
  logic [WIDTH-1:0]            radd;
  logic [WIDTH-1:0]            hdec;

  assign ch_ok  = {1'b0, ch} < (CHW+1)'(NCH);
  assign hsel   = ch_ok ? head_q[ch] : '0;
  assign rr_big = {1'b0, result_reg} >= DEP;
  assign rr     = rr_big ? result_reg - DLO : result_reg;
  assign sum    = {1'b0, hsel} + {1'b0, rr};
  assign radd   = (sum >= DEP) ? WIDTH'(sum - DEP) : sum[WIDTH-1:0];
  // The ring walks downward: a new sample moves the head back one slot.
  assign hdec   = (hsel == '0) ? DMAX : hsel - 1'b1;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ich_d   = ich_q;
    head_d  = head_q;
    ares_d  = ares_q;
    aerr_d  = aerr_q;
    vld_d   = 1'b0;
    oob_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (en_init) begin
          if (ch_ok) begin
            ich_d   = ch;
            cnt_d   = '0;
            state_d = INIT;
          end
        end else if (ch_ok) begin
          if (en_load) begin
            ares_d = out_smp ? hsel : radd;
            aerr_d = error_reg;
            vld_d  = 1'b1;
            oob_d  = rr_big;
          end
          if (new_smp) head_d[ch] = hdec;
        end
      end
      INIT: begin
        ares_d = cnt_q;
        aerr_d = cnt_q;
        vld_d  = 1'b1;
        if (cnt_q == DMAX) begin
          head_d[ich_q] = '0;
          cnt_d         = '0;
          state_d       = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ich_q   <= '0;
      head_q  <= '0;
      ares_q  <= '0;
      aerr_q  <= '0;
      vld_q   <= 1'b0;
      oob_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ich_q   <= ich_d;
      head_q  <= head_d;
      ares_q  <= ares_d;
      aerr_q  <= aerr_d;
      vld_q   <= vld_d;
      oob_q   <= oob_d;
    end
  end

  assign ares     = ares_q;
  assign aerr     = aerr_q;
  assign head     = hsel;
  assign addr_vld = vld_q;
  assign oob      = oob_q;
  assign busy     = (state_q == INIT);

endmodule

// File: tb/tb_ctrl_ringaddr.sv
// Directed bench for ctrl_ringaddr with DEPTH=6, WIDTH=3, NCH=2.
// Inputs change at rising edges; the DUT updates on falling edges.
module tb_ctrl_ringaddr;

  logic       clk;
  logic       rst;
  logic [0:0] ch;
  logic       en_init;
  logic       en_load;
  logic       new_smp;
  logic       out_smp;
  logic [2:0] result_reg;
  logic [2:0] error_reg;
  logic [2:0] ares;
  logic [2:0] aerr;
  logic [2:0] head;
  logic       addr_vld;
  logic       busy;
  logic       oob;

  int tests = 0;
  int fails = 0;

  ctrl_ringaddr #(.WIDTH(3), .DEPTH(6), .NCH(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .ch         (ch),
    .en_init    (en_init),
    .en_load    (en_load),
    .new_smp    (new_smp),
    .out_smp    (out_smp),
    .result_reg (result_reg),
    .error_reg  (error_reg),
    .ares       (ares),
    .aerr       (aerr),
    .head       (head),
    .addr_vld   (addr_vld),
    .busy       (busy),
    .oob        (oob)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  // one falling-edge update, returning at the following rising edge
  task automatic cyc();
    @(negedge clk);
    @(posedge clk);
  endtask

  task automatic idle_in();
    en_init    = 1'b0;
    en_load    = 1'b0;
    new_smp    = 1'b0;
    out_smp    = 1'b0;
  endtask

  initial begin
    rst        = 1'b1;
    ch         = 1'b0;
    result_reg = 3'd0;
    error_reg  = 3'd0;
    idle_in();
    #1 rst = 1'b0;
    cyc();
    cyc();
    chk("rst_ares", ares, 0);
    chk("rst_aerr", aerr, 0);
    chk("rst_vld", addr_vld, 0);
    chk("rst_busy", busy, 0);
    chk("rst_oob", oob, 0);
    chk("rst_head", head, 0);
    rst = 1'b1;
    cyc();

    // init sweep on channel 1
    ch = 1'b1;
    en_init = 1'b1;
    cyc();
    idle_in();
    chk("init_busy0", busy, 1);
    chk("init_vld0", addr_vld, 0);
    for (int i = 0; i < 6; i++) begin
      cyc();
      chk("sweep_ares", ares, i);
      chk("sweep_aerr", aerr, i);
      chk("sweep_vld", addr_vld, 1);
      chk("sweep_busy", busy, (i < 5) ? 1 : 0);
    end
    cyc();
    chk("post_sweep_vld", addr_vld, 0);
    chk("post_sweep_head1", head, 0);

    // head[0] wraps 0 -> 5, then (5+3) mod 6 = 2
    ch = 1'b0;
    new_smp = 1'b1;
    cyc();
    idle_in();
    chk("dec_wrap_head", head, 5);
    chk("dec_vld", addr_vld, 0);
    en_load = 1'b1;
    result_reg = 3'd3;
    error_reg = 3'd6;
    cyc();
    idle_in();
    chk("load_ares", ares, 2);
    chk("load_aerr", aerr, 6);
    chk("load_vld", addr_vld, 1);
    chk("load_oob", oob, 0);
    cyc();
    chk("hold_ares", ares, 2);
    chk("hold_vld", addr_vld, 0);

    // head[0]=4, result_reg 7 -> 1, ares 5, oob
    new_smp = 1'b1;
    cyc();
    idle_in();
    chk("dec_head4", head, 4);
    en_load = 1'b1;
    result_reg = 3'd7;
    error_reg = 3'd1;
    cyc();
    idle_in();
    chk("oob_flag", oob, 1);
    chk("oob_ares", ares, 5);
    chk("oob_aerr", aerr, 1);
    cyc();
    chk("oob_clear", oob, 0);
    chk("oob_hold", ares, 5);

    // head[1] 0 -> 5 -> 4 -> 3
    ch = 1'b1;
    new_smp = 1'b1;
    cyc();
    cyc();
    cyc();
    idle_in();
    chk("head1_3", head, 3);
    ch = 1'b0;
    #1 chk("head0_kept", head, 4);
    ch = 1'b1;
    en_load = 1'b1;
    out_smp = 1'b1;
    result_reg = 3'd2;
    error_reg = 3'd7;
    cyc();
    idle_in();
    chk("outsmp_ares", ares, 3);
    chk("outsmp_aerr", aerr, 7);
    chk("outsmp_vld", addr_vld, 1);

    // init wins over load
    en_init = 1'b1;
    en_load = 1'b1;
    result_reg = 3'd1;
    error_reg = 3'd2;
    cyc();
    idle_in();
    chk("prio_busy", busy, 1);
    chk("prio_vld", addr_vld, 0);
    chk("prio_ares", ares, 3);
    chk("prio_aerr", aerr, 7);
    en_load = 1'b1;
    new_smp = 1'b1;
    cyc();
    chk("sw1_ares", ares, 0);
    cyc();
    idle_in();
    chk("sw2_ares", ares, 1);
    cyc();
    chk("sw3_ares", ares, 2);
    chk("sw3_busy", busy, 1);

    // async reset mid-sweep
    #2 rst = 1'b0;
    #1;
    chk("arst_ares", ares, 0);
    chk("arst_aerr", aerr, 0);
    chk("arst_vld", addr_vld, 0);
    chk("arst_busy", busy, 0);
    chk("arst_oob", oob, 0);
    chk("arst_head1", head, 0);
    #1 rst = 1'b1;
    @(posedge clk);
    ch = 1'b0;
    en_load = 1'b1;
    result_reg = 3'd2;
    error_reg = 3'd3;
    cyc();
    idle_in();
    chk("after_rst_ares", ares, 2);
    chk("after_rst_busy", busy, 0);
    chk("after_rst_vld", addr_vld, 1);

    // load and new sample together on ch 1
    ch = 1'b1;
    en_load = 1'b1;
    new_smp = 1'b1;
    result_reg = 3'd1;
    error_reg = 3'd4;
    cyc();
    idle_in();
    chk("coinc_ares", ares, 1);
    chk("coinc_aerr", aerr, 4);
    chk("coinc_head1", head, 5);
    ch = 1'b0;
    #1 chk("coinc_head0", head, 0);

    // boundary: (5+5) mod 6 = 4
    ch = 1'b1;
    en_load = 1'b1;
    result_reg = 3'd5;
    error_reg = 3'd0;
    cyc();
    idle_in();
    chk("wrap_ares", ares, 4);
    chk("wrap_oob", oob, 0);
    chk("wrap_head1", head, 5);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
